// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial stimulus stage: takes a word over valid/ready, shifts it out
// one bit per clock on `a`, then holds IDLE_LEVEL for GAP cycles before the next word.
module fsm_bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   GAP        = 2,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter bit   MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
    localparam int GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             a_q, a_d;
    logic             a_valid_q, a_valid_d;
    logic             busy_q, busy_d;
    logic             word_done_q, word_done_d;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign load_ready = (state_q == S_IDLE) && rst;

    // Outputs are computed for the coming cycle, so the bit captured at the
    // transfer edge is already on `a` in the first cycle of SHIFT.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        a_d         = IDLE_LEVEL;
        a_valid_d   = 1'b0;
        word_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_valid && load_ready) begin
                    state_d     = S_SHIFT;
                    a_d         = head_bit(load_data);
                    a_valid_d   = 1'b1;
                    word_done_d = (WIDTH == 1);
                    shreg_d     = shift_out(load_data);
                    bit_cnt_d   = BW'(WIDTH - 1);
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == '0) begin
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GW'(GAP_M1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    a_d         = head_bit(shreg_q);
                    a_valid_d   = 1'b1;
                    word_done_d = (bit_cnt_q == BW'(1));
                    shreg_d     = shift_out(shreg_q);
                    bit_cnt_d   = bit_cnt_q - BW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) state_d = S_IDLE;
                else                 gap_cnt_d = gap_cnt_q - GW'(1);
            end
            default: begin
                state_d   = S_IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            a_q         <= IDLE_LEVEL;
            a_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            a_q         <= a_d;
            a_valid_q   <= a_valid_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
        end
    end

    assign a         = a_q;
    assign a_valid   = a_valid_q;
    assign busy      = busy_q;
    assign word_done = word_done_q;

endmodule
